fnd_scan_capture: RTL and testbench
===================================

FND_SCAN_CAPTURE -- requirements
Module: fnd_scan_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical-sample count required to accept a digit; legal range 1..255.
REQ-002 Port i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port i_reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port i_com  input  4  SHALL be the scanned digit-select lines, active-low, one-hot-low when valid (bit n low = digit n driven).
REQ-005 Port i_font  input  8  SHALL be the active-low segment lines, bit 7 = dp, bits 6..0 = g..a.
REQ-006 Port o_bcd  output  16  SHALL hold the last completed frame, digit n in bits [4n+3:4n].
REQ-007 Port o_valid  output  1  SHALL pulse high one cycle when o_bcd is updated.
REQ-008 Port o_err  output  1  SHALL be high while o_bcd holds a frame containing any unrecognised font.

Function
REQ-009 Inputs are in the i_clk domain; no synchroniser is required.
REQ-010 Font-to-value map SHALL be: c0->0, f9->1, a4->2, b0->3, 99->4, 92->5, 82->6, f8->7, 80->8, 90->9, 7f->a, ff->f (blank); any other font -> e with the invalid flag set.
REQ-011 A sample is the pair {i_com, i_font}; valid i_com is exactly one bit low (e, d, b, 7).
REQ-012 FSM states SHALL be IDLE, SETTLE, HOLD.
REQ-013 IDLE: on a valid i_com, go to SETTLE with count = 1 and the sample registered; otherwise stay.
REQ-014 SETTLE: sample equal to registered -> count+1; sample differs but valid -> restart with count = 1 on new sample; invalid i_com -> IDLE, count cleared.
REQ-015 When count reaches STABLE_CYCLES, the decoded value SHALL be written to the slot selected by i_com on that same edge, the slot's seen bit set, slot's invalid flag recorded, and FSM to HOLD; STABLE_CYCLES = 1 captures on the first valid sample's edge.
REQ-016 HOLD: no further capture while the sample is unchanged; any change -> SETTLE (valid i_com, count = 1) or IDLE (invalid i_com).
REQ-017 Recapture of an already-seen digit before frame completion SHALL overwrite its slot and invalid flag.
REQ-018 When the seen mask becomes 1111, on the next edge o_bcd SHALL load all four slots, o_err SHALL load the OR of the four invalid flags, o_valid SHALL be high for exactly that cycle, and the seen mask SHALL clear.
REQ-019 A capture occurring on the same edge as the frame load SHALL be retained in its slot and set its seen bit in the new (cleared) mask.
REQ-020 o_bcd and o_err SHALL hold between frames; count SHALL saturate at STABLE_CYCLES.

Reset
REQ-021 While i_reset is high on an edge: FSM -> IDLE, count 0, seen mask 0000, slots 0, invalid flags 0, o_bcd 16'h0000, o_valid 0, o_err 0.
REQ-022 Reset mid-frame SHALL discard partial captures; the next frame requires all four digits anew.

Structure
REQ-023 Shared package SHALL hold the FSM state encoding, the font constants (c0..7f, ff) and the invalid code 4'he.
REQ-024 One combinational sub-module fnd_font_decoder SHALL implement the REQ-010 map (value + invalid flag).

Verification
REQ-025 Reset, then scan e/c0, d/f9, b/a4, 7/b0, each held 4 cycles -> one o_valid pulse, o_bcd = 16'h3210, o_err = 0.
REQ-026 Hold e/92 for only 3 cycles, then d/f9 -> digit 0 not captured, no o_valid after the remaining digits until e is rescanned for 4 cycles.
REQ-027 Frame with digit 2 font = 8'h00 -> o_bcd[11:8] = e, o_err = 1; next clean frame -> o_err = 0.
REQ-028 i_com = 4'b1100 or 4'b1111 for 10 cycles with any font -> no capture, FSM in IDLE.
REQ-029 Scan digit 0 twice (c0 then 90) before completing the frame -> o_bcd[3:0] = 9.
REQ-030 Assert i_reset after three digits captured -> all outputs zero; a full frame is then needed for o_valid.

Source files
------------

// File: rtl/fnd_scan_capture_pkg.sv
// ---------------------------------------------------------------------------
// fnd_scan_capture_pkg
// Shared definitions for the seven-segment scan capture block:
//   - FSM state encoding
//   - active-low font constants for the recognised glyphs
//   - invalid-glyph code
//   - digit-select helpers (validity check, slot index)
// ---------------------------------------------------------------------------
package fnd_scan_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Active-low segments: bit 7 = dp, bits 6..0 = g..a
   localparam logic [7:0] FONT_0     = 8'hc0;
   localparam logic [7:0] FONT_1     = 8'hf9;
   localparam logic [7:0] FONT_2     = 8'ha4;
   localparam logic [7:0] FONT_3     = 8'hb0;
   localparam logic [7:0] FONT_4     = 8'h99;
   localparam logic [7:0] FONT_5     = 8'h92;
   localparam logic [7:0] FONT_6     = 8'h82;
   localparam logic [7:0] FONT_7     = 8'hf8;
   localparam logic [7:0] FONT_8     = 8'h80;
   localparam logic [7:0] FONT_9     = 8'h90;
   localparam logic [7:0] FONT_DP    = 8'h7f;
   localparam logic [7:0] FONT_BLANK = 8'hff;

   localparam logic [3:0] CODE_DP      = 4'ha;
   localparam logic [3:0] CODE_BLANK   = 4'hf;
   localparam logic [3:0] CODE_INVALID = 4'he;

   localparam logic [3:0] COM_D0 = 4'b1110;
   localparam logic [3:0] COM_D1 = 4'b1101;
   localparam logic [3:0] COM_D2 = 4'b1011;
   localparam logic [3:0] COM_D3 = 4'b0111;

   // Exactly one digit-select line low
   function automatic logic com_is_valid(input logic [3:0] com);
      return (com == COM_D0) || (com == COM_D1) ||
             (com == COM_D2) || (com == COM_D3);
   endfunction

   function automatic logic [1:0] com_index(input logic [3:0] com);
      logic [1:0] idx;
      case (com)
         COM_D1:  idx = 2'd1;
         COM_D2:  idx = 2'd2;
         COM_D3:  idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/fnd_scan_capture_if.sv
// ---------------------------------------------------------------------------
// fnd_scan_capture_if
// Bundles the scanned display lines and the captured-frame outputs.
//   i_com   [3:0]  digit select, active-low, one-hot-low when valid
//   i_font  [7:0]  segment lines, active-low
//   o_bcd   [15:0] last completed frame, digit n in [4n+3:4n]
//   o_valid        one-cycle pulse when o_bcd updates
//   o_err          frame in o_bcd contains an unrecognised glyph
// master: the display scanner side; slave: the capture block.
// ---------------------------------------------------------------------------
interface fnd_scan_capture_if;

   logic [3:0]  i_com;
   logic [7:0]  i_font;
   logic [15:0] o_bcd;
   logic        o_valid;
   logic        o_err;

   modport master (
      output i_com,
      output i_font,
      input  o_bcd,
      input  o_valid,
      input  o_err
   );

   modport slave (
      input  i_com,
      input  i_font,
      output o_bcd,
      output o_valid,
      output o_err
   );

endinterface

// File: rtl/fnd_font_decoder.sv
// ---------------------------------------------------------------------------
// fnd_font_decoder
// Combinational map from an active-low seven-segment glyph to its 4-bit code.
//   font    [7:0] active-low segments (dp, g..a)
//   value   [3:0] decoded digit, 4'ha for dp-only, 4'hf for blank,
//                 4'he for anything unrecognised
//   invalid       high when the glyph is unrecognised
// ---------------------------------------------------------------------------
module fnd_font_decoder
   import fnd_scan_capture_pkg::*;
(
   input  logic [7:0] font,
   output logic [3:0] value,
   output logic       invalid
);

   always_comb begin
      value   = CODE_INVALID;
      invalid = 1'b0;
      case (font)
         FONT_0:     value = 4'h0;
         FONT_1:     value = 4'h1;
         FONT_2:     value = 4'h2;
         FONT_3:     value = 4'h3;
         FONT_4:     value = 4'h4;
         FONT_5:     value = 4'h5;
         FONT_6:     value = 4'h6;
         FONT_7:     value = 4'h7;
         FONT_8:     value = 4'h8;
         FONT_9:     value = 4'h9;
         FONT_DP:    value = CODE_DP;
         FONT_BLANK: value = CODE_BLANK;
         default: begin
            value   = CODE_INVALID;
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fnd_scan_capture.sv
// ---------------------------------------------------------------------------
// fnd_scan_capture
// Watches a multiplexed four-digit seven-segment display and reconstructs
// the displayed value. A digit is accepted once the same {com, font} sample
// has been seen for STABLE_CYCLES consecutive clocks; when all four digits
// have been accepted the frame is published on o_bcd with a one-cycle
// o_valid pulse.
//   i_clk    clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      fnd_scan_capture_if.slave (scan inputs, frame outputs)
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no valid digit select present
//   ST_SETTLE | valid sample registered, counting identical samples
//   ST_HOLD   | sample captured; waiting for it to change
// ---------------------------------------------------------------------------
module fnd_scan_capture
   import fnd_scan_capture_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
)
(
   input  logic              i_clk,
   input  logic              i_reset,
   fnd_scan_capture_if.slave bus
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   state_t      state_q, state_d;
   logic [11:0] sample_q, sample_d;
   logic [7:0]  count_q, count_d;
   logic        capture;

   logic [15:0] slots_q;
   logic [3:0]  inv_q;
   logic [3:0]  seen_q, seen_d;
   logic        frame_load;

   logic [15:0] bcd_q;
   logic        valid_q;
   logic        err_q;

   logic [11:0] cur_sample;
   logic        cur_valid;
   logic [1:0]  cur_idx;
   logic [3:0]  dec_value;
   logic        dec_invalid;

   assign cur_sample = {bus.i_com, bus.i_font};
   assign cur_valid  = com_is_valid(bus.i_com);
   assign cur_idx    = com_index(bus.i_com);

   fnd_font_decoder u_decoder (
      .font    (bus.i_font),
      .value   (dec_value),
      .invalid (dec_invalid)
   );

   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      count_d  = count_q;
      capture  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cur_valid) begin
               sample_d = cur_sample;
               count_d  = 8'd1;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!cur_valid) begin
               count_d = 8'd0;
               state_d = ST_IDLE;
            end else if (cur_sample == sample_q) begin
               if (count_q < STABLE) begin
                  count_d = count_q + 8'd1;
               end
            end else begin
               sample_d = cur_sample;
               count_d  = 8'd1;
            end
         end
         ST_HOLD: begin
            if (cur_sample != sample_q) begin
               if (!cur_valid) begin
                  count_d = 8'd0;
                  state_d = ST_IDLE;
               end else begin
                  sample_d = cur_sample;
                  count_d  = 8'd1;
                  state_d  = ST_SETTLE;
               end
            end
         end
         default: begin
            count_d = 8'd0;
            state_d = ST_IDLE;
         end
      endcase

      // Accept on the edge the count reaches the threshold; this also covers
      // STABLE_CYCLES = 1, where the first valid sample is captured directly.
      if ((state_d == ST_SETTLE) && (count_d == STABLE)) begin
         capture = 1'b1;
         state_d = ST_HOLD;
      end
   end

   // A capture coincident with the frame load lands in the fresh mask.
   always_comb begin
      frame_load = &seen_q;
      seen_d     = frame_load ? 4'b0000 : seen_q;
      if (capture) begin
         seen_d[cur_idx] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         sample_q <= '0;
         count_q  <= '0;
         slots_q  <= '0;
         inv_q    <= '0;
         seen_q   <= '0;
         bcd_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         count_q  <= count_d;
         seen_q   <= seen_d;
         valid_q  <= frame_load;

         if (capture) begin
            slots_q[cur_idx*4 +: 4] <= dec_value;
            inv_q[cur_idx]          <= dec_invalid;
         end

         if (frame_load) begin
            bcd_q <= slots_q;
            err_q <= |inv_q;
         end
      end
   end

   assign bus.o_bcd   = bcd_q;
   assign bus.o_valid = valid_q;
   assign bus.o_err   = err_q;

endmodule

// File: tb/tb_fnd_scan_capture.sv
module tb_fnd_scan_capture;
   import fnd_scan_capture_pkg::*;

   localparam int STABLE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fnd_scan_capture_if bus ();

   fnd_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int vcnt = 0;

   // Reference model state
   logic [7:0]  font_tab [12] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92,
                                  8'h82, 8'hf8, 8'h80, 8'h90, 8'h7f, 8'hff};
   logic [3:0]  val_tab  [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hf};
   logic [3:0]  m_slot [4];
   bit          m_inv  [4];
   bit          m_seen [4];
   logic [15:0] m_bcd = '0;
   logic        m_err = 1'b0;
   logic        m_valid = 1'b0;
   int          run = 0;
   logic [11:0] prev = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int digit_of(input logic [3:0] com);
      int d = -1;
      int zeros = 0;
      for (int i = 0; i < 4; i++) begin
         if (com[i] == 1'b0) begin
            zeros++;
            d = i;
         end
      end
      return (zeros == 1) ? d : -1;
   endfunction

   task automatic model_edge(input logic [3:0] com, input logic [7:0] font, input logic r);
      int d;
      bit all_seen;
      bit cap;
      logic [3:0] val;
      bit bad;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            m_slot[i] = 4'h0; m_inv[i] = 0; m_seen[i] = 0;
         end
         m_bcd = '0; m_err = 0; m_valid = 0; run = 0;
         return;
      end
      d = digit_of(com);
      all_seen = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
      if (d < 0) run = 0;
      else if (run > 0 && {com, font} == prev) run++;
      else run = 1;
      prev = {com, font};
      cap = (d >= 0) && (run == STABLE);
      m_valid = all_seen;
      if (all_seen) begin
         m_bcd = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
         m_err = m_inv[0] | m_inv[1] | m_inv[2] | m_inv[3];
         for (int i = 0; i < 4; i++) m_seen[i] = 0;
      end
      if (cap) begin
         val = 4'he; bad = 1;
         for (int i = 0; i < 12; i++) begin
            if (font_tab[i] == font) begin
               val = val_tab[i]; bad = 0;
            end
         end
         m_slot[d] = val; m_inv[d] = bad; m_seen[d] = 1;
      end
   endtask

   task automatic step(input logic [3:0] com, input logic [7:0] font, input logic r);
      bus.i_com = com;
      bus.i_font = font;
      rst = r;
      @(posedge clk);
      model_edge(com, font, r);
      #1;
      chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
      chk("o_bcd", 32'(bus.o_bcd), 32'(m_bcd));
      chk("o_err", 32'(bus.o_err), 32'(m_err));
      if (bus.o_valid === 1'b1) vcnt++;
   endtask

   task automatic hold(input logic [3:0] com, input logic [7:0] font, input int n);
      for (int i = 0; i < n; i++) step(com, font, 1'b0);
   endtask

   task automatic clean_frame();
      hold(4'he, 8'hc0, 4);
      hold(4'hd, 8'hf9, 4);
      hold(4'hb, 8'ha4, 4);
      hold(4'h7, 8'hb0, 4);
   endtask

   initial begin
      int v0;
      int seg_len;
      logic [3:0] rc;
      logic [7:0] rf;
      logic [3:0] coms [4] = '{4'he, 4'hd, 4'hb, 4'h7};

      bus.i_com = 4'hf;
      bus.i_font = 8'hff;

      // Reset state
      step(4'hf, 8'hff, 1'b1);
      step(4'he, 8'hc0, 1'b1);
      chk("reset_bcd", 32'(bus.o_bcd), 32'h0);
      chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));

      // Basic frame
      v0 = vcnt;
      clean_frame();
      step(4'hf, 8'hff, 1'b0);
      chk("basic_valid", 32'(bus.o_valid), 32'h1);
      chk("basic_bcd", 32'(bus.o_bcd), 32'h3210);
      chk("basic_err", 32'(bus.o_err), 32'h0);
      hold(4'hf, 8'hff, 3);
      chk("basic_one_pulse", 32'(vcnt - v0), 32'h1);

      // Short hold on digit 0 is not captured
      step(4'hf, 8'hff, 1'b1);
      v0 = vcnt;
      hold(4'he, 8'h92, 3);
      hold(4'hd, 8'hf9, 4);
      hold(4'hb, 8'ha4, 4);
      hold(4'h7, 8'hb0, 4);
      hold(4'hf, 8'hff, 3);
      chk("short_no_valid", 32'(vcnt - v0), 32'h0);
      hold(4'he, 8'h92, 4);
      step(4'hf, 8'hff, 1'b0);
      chk("short_valid", 32'(bus.o_valid), 32'h1);
      chk("short_bcd", 32'(bus.o_bcd), 32'h3215);

      // Unrecognised font in digit 2
      hold(4'he, 8'hc0, 4);
      hold(4'hd, 8'hf9, 4);
      hold(4'hb, 8'h00, 4);
      hold(4'h7, 8'hb0, 4);
      step(4'hf, 8'hff, 1'b0);
      chk("bad_digit2", 32'(bus.o_bcd[11:8]), 32'he);
      chk("bad_err", 32'(bus.o_err), 32'h1);
      clean_frame();
      step(4'hf, 8'hff, 1'b0);
      chk("clean_err", 32'(bus.o_err), 32'h0);
      chk("clean_bcd", 32'(bus.o_bcd), 32'h3210);

      // Invalid digit selects
      v0 = vcnt;
      hold(4'b1100, 8'hc0, 10);
      chk("multi_low_idle", 32'(dut.state_q), 32'(ST_IDLE));
      hold(4'b1111, 8'hf9, 10);
      chk("none_low_idle", 32'(dut.state_q), 32'(ST_IDLE));
      chk("invalid_no_valid", 32'(vcnt - v0), 32'h0);

      // Recapture of digit 0 overwrites
      hold(4'he, 8'hc0, 4);
      hold(4'he, 8'h90, 4);
      hold(4'hd, 8'hf9, 4);
      hold(4'hb, 8'ha4, 4);
      hold(4'h7, 8'hb0, 4);
      step(4'hf, 8'hff, 1'b0);
      chk("recap_digit0", 32'(bus.o_bcd[3:0]), 32'h9);

      // Reset mid-frame
      hold(4'he, 8'hc0, 4);
      hold(4'hd, 8'hf9, 4);
      hold(4'hb, 8'ha4, 4);
      step(4'hf, 8'hff, 1'b1);
      chk("midrst_bcd", 32'(bus.o_bcd), 32'h0);
      chk("midrst_err", 32'(bus.o_err), 32'h0);
      chk("midrst_valid", 32'(bus.o_valid), 32'h0);
      v0 = vcnt;
      hold(4'hd, 8'hf9, 4);
      hold(4'hb, 8'ha4, 4);
      hold(4'h7, 8'hb0, 4);
      hold(4'hf, 8'hff, 2);
      chk("midrst_no_valid", 32'(vcnt - v0), 32'h0);
      hold(4'he, 8'hc0, 4);
      step(4'hf, 8'hff, 1'b0);
      chk("midrst_full_valid", 32'(bus.o_valid), 32'h1);
      chk("midrst_full_bcd", 32'(bus.o_bcd), 32'h3210);

      // Randomized scanning against the reference model
      for (int s = 0; s < 120; s++) begin
         if ($urandom_range(0, 9) == 0) rc = 4'($urandom_range(0, 15));
         else rc = coms[$urandom_range(0, 3)];
         if ($urandom_range(0, 7) == 0) rf = 8'($urandom_range(0, 255));
         else rf = font_tab[$urandom_range(0, 11)];
         seg_len = $urandom_range(1, 6);
         if ($urandom_range(0, 49) == 0) step(rc, rf, 1'b1);
         hold(rc, rf, seg_len);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
